clk_divider: RTL

CLK_DIVIDER -- requirements
Module: clk_divider

---
 rtl/clk_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/clk_divider.sv
// Programmable clock divider with a glitch-free registered output.
// The divisor gives the half-period in clk cycles; a divisor of 0 acts as 1.
// Reloads while running are held in a shadow register and take effect at
// the next half-period boundary. Dropping en while the output is high lets
// the current high phase finish before the divider returns to idle.
module clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_ld,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [15:0]      rise_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] div_act_reg;
  logic [WIDTH-1:0] div_shd_reg;
  logic             pend_reg;
  logic             clk_out_reg;
  logic             tick_reg;
  logic [15:0]      rise_cnt_reg;

  logic [WIDTH-1:0] div_eff;
  logic             terminal;

  // A zero divisor behaves exactly like a divisor of one.
  assign div_eff  = (div_act_reg == '0) ? WIDTH'(1) : div_act_reg;
  // Last cycle of the current half-period.
  assign terminal = (cnt_reg == (div_eff - WIDTH'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a high phase is never cut short, a low phase may be.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Leaving straight to IDLE is safe when low, or when high on its last cycle.
          state_next = (clk_out_reg && !terminal) ? STOP : IDLE;
        end
      end
      STOP: begin
        if (en) begin
          state_next = RUN;
        end else if (terminal) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs that depend on state only.
  always_comb begin
    busy = (state_reg != IDLE);
  end

  // Half-period counter, output toggle, divisor shadowing and rise counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      clk_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      rise_cnt_reg <= 16'd0;
      div_act_reg  <= WIDTH'(DEFAULT_DIV);
      div_shd_reg  <= WIDTH'(DEFAULT_DIV);
      pend_reg     <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (state_next == IDLE) begin
        // Idle (or entering idle): output parked low, any pending divisor applied.
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
        pend_reg    <= 1'b0;
        if (div_ld) begin
          div_act_reg <= div_in;
          div_shd_reg <= div_in;
        end else if (pend_reg) begin
          div_act_reg <= div_shd_reg;
        end
      end else if (state_reg == IDLE) begin
        // Start of run: first half-period is low and begins counting from zero.
        cnt_reg     <= '0;
        clk_out_reg <= 1'b0;
        if (div_ld) begin
          div_act_reg <= div_in;
          div_shd_reg <= div_in;
        end
      end else begin
        if (terminal) begin
          cnt_reg     <= '0;
          clk_out_reg <= ~clk_out_reg;
          if (!clk_out_reg) begin
            tick_reg     <= 1'b1;
            rise_cnt_reg <= rise_cnt_reg + 16'd1;
          end
          // The shadow divisor governs the half-period that starts now.
          if (pend_reg) begin
            div_act_reg <= div_shd_reg;
          end
        end else begin
          cnt_reg <= cnt_reg + WIDTH'(1);
        end
        if (div_ld) begin
          div_shd_reg <= div_in;
          pend_reg    <= 1'b1;
        end else if (terminal) begin
          pend_reg <= 1'b0;
        end
      end
    end
  end

  assign clk_out  = clk_out_reg;
  assign tick     = tick_reg;
  assign rise_cnt = rise_cnt_reg;

endmodule
